// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and one-shot state encoding for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int PC_W_DEF     = 32;
  localparam int SLOT_OFS_DEF = 8;

  typedef enum logic {
    OS_IDLE  = 1'b0,
    OS_FIRED = 1'b1
  } os_state_t;

endpackage

// File: rtl/branch_resolve_unit_oneshot_stage_ctrl.sv
// Emits one pulse per instruction instance occupying a pipeline stage,
// however long that stage is held.
module oneshot_stage_ctrl
  import branch_resolve_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic hold,
  input  logic advance,
  output logic pulse
);

  os_state_t state;
  os_state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= OS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OS_IDLE:  if (trigger && hold) state_next = OS_FIRED;
      OS_FIRED: if (advance)         state_next = OS_IDLE;
      default:                       state_next = OS_IDLE;
    endcase
  end

  // Gated by rst so a stage still holding stale content cannot fire during reset.
  always_comb begin
    pulse = !rst && trigger && (state == OS_IDLE);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries branch predictions D->E->M, flags mispredicts in E, issues one
// predictor training update per retired branch in M, and counts both.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int CNT_W    = 32,
  parameter int SLOT_OFS = SLOT_OFS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             stallM,
  input  logic             flushM,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [PC_W-1:0]  pcD,
  input  logic [PC_W-1:0]  targetD,
  input  logic             actual_takeE,
  output logic             pred_wrongE,
  output logic [PC_W-1:0]  redirect_pcE,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [PC_W-1:0]  pcM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            validE, branchE, predE;
  logic [PC_W-1:0] pcE, targetE;
  logic            validM, mispredM;
  logic            mismatchE;

  always_ff @(posedge clk) begin
    if (rst) begin
      validE  <= 1'b0;
      branchE <= 1'b0;
      predE   <= 1'b0;
      pcE     <= '0;
      targetE <= '0;
    end else if (flushE) begin
      validE  <= 1'b0;
    end else if (!stallE) begin
      validE  <= 1'b1;
      branchE <= branchD;
      predE   <= pred_takeD;
      pcE     <= pcD;
      targetE <= targetD;
    end
  end

  assign mismatchE = validE && branchE && (predE != actual_takeE);

  oneshot_stage_ctrl u_e_ctrl (
    .clk     (clk),
    .rst     (rst),
    .trigger (mismatchE),
    .hold    (stallE && !flushE),
    .advance (!stallE || flushE),
    .pulse   (pred_wrongE)
  );

  // Only meaningful alongside the pulse; held at zero otherwise.
  always_comb begin
    redirect_pcE = '0;
    if (pred_wrongE)
      redirect_pcE = actual_takeE ? targetE : (pcE + PC_W'(SLOT_OFS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validM       <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= '0;
      mispredM     <= 1'b0;
    end else if (flushM) begin
      validM       <= 1'b0;
    end else if (!stallM) begin
      validM       <= validE && branchE;
      actual_takeM <= actual_takeE;
      pcM          <= pcE;
      mispredM     <= mismatchE;
    end
  end

  oneshot_stage_ctrl u_m_ctrl (
    .clk     (clk),
    .rst     (rst),
    .trigger (validM),
    .hold    (stallM && !flushM),
    .advance (!stallM || flushM),
    .pulse   (branchM)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (branchM) begin
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredM && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: mispredict pulses, redirects,
// stall one-shot behaviour, flush, counter saturation and reset.
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallE, flushE, stallM, flushM;
  logic             branchD, pred_takeD, actual_takeE;
  logic [PC_W-1:0]  pcD, targetD;
  logic             pred_wrongE, branchM, actual_takeM;
  logic [PC_W-1:0]  redirect_pcE, pcM;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int errors = 0;
  int checks = 0;
  int pw_total = 0;
  int bm_total = 0;
  int pw_base, bm_base;

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(CNT_W), .SLOT_OFS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallE       (stallE),
    .flushE       (flushE),
    .stallM       (stallM),
    .flushM       (flushM),
    .branchD      (branchD),
    .pred_takeD   (pred_takeD),
    .pcD          (pcD),
    .targetD      (targetD),
    .actual_takeE (actual_takeE),
    .pred_wrongE  (pred_wrongE),
    .redirect_pcE (redirect_pcE),
    .branchM      (branchM),
    .actual_takeM (actual_takeM),
    .pcM          (pcM),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse counters sampled just before each active edge.
  always @(posedge clk) begin
    if (pred_wrongE === 1'b1) pw_total <= pw_total + 1;
    if (branchM === 1'b1)     bm_total <= bm_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at the sampling point.
  task automatic cyc(input logic bd, input logic pd, input logic [PC_W-1:0] pc,
                     input logic [PC_W-1:0] tgt, input logic ae, input logic se,
                     input logic fe, input logic sm, input logic fm);
    @(posedge clk);
    #1;
    branchD = bd; pred_takeD = pd; pcD = pc; targetD = tgt;
    actual_takeE = ae; stallE = se; flushE = fe; stallM = sm; flushM = fm;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic snap();
    pw_base = pw_total;
    bm_base = bm_total;
  endtask

  initial begin
    rst = 1'b1;
    branchD = 0; pred_takeD = 0; pcD = '0; targetD = '0; actual_takeE = 0;
    stallE = 0; flushE = 0; stallM = 0; flushM = 0;
    idle(2);
    check("rst_pred_wrong", pred_wrongE, 0);
    check("rst_redirect",   redirect_pcE, 0);
    check("rst_branchM",    branchM, 0);
    check("rst_pcM",        pcM, 0);
    check("rst_actualM",    actual_takeM, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    rst = 1'b0;

    // Predicted not-taken, actually taken
    snap();
    cyc(1, 0, 32'h0040_0010, 32'h0040_0100, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    check("t1_pulse",    pred_wrongE, 1);
    check("t1_redirect", redirect_pcE, 32'h0040_0100);
    cyc(0, 0, '0, '0, 0, 0, 0, 0, 0);
    check("t1_pulse_off", pred_wrongE, 0);
    check("t1_branchM",  branchM, 1);
    check("t1_pcM",      pcM, 32'h0040_0010);
    check("t1_actualM",  actual_takeM, 1);
    cyc(0, 0, '0, '0, 0, 0, 0, 0, 0);
    check("t1_branchM_off", branchM, 0);
    check("t1_branch_cnt",  branch_cnt, 1);
    check("t1_mispred_cnt", mispred_cnt, 1);
    check("t1_pw_count", pw_total - pw_base, 1);

    // Predicted taken, actually not-taken: fall-through past delay slot
    snap();
    cyc(1, 1, 32'h0040_0020, 32'h0040_0200, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, '0, 0, 0, 0, 0, 0);
    check("t2_pulse",    pred_wrongE, 1);
    check("t2_redirect", redirect_pcE, 32'h0040_0028);
    idle(2);
    check("t2_pw_count", pw_total - pw_base, 1);
    check("t2_mispred_cnt", mispred_cnt, 2);

    // Correct prediction while E stalls 3 cycles (M takes bubbles)
    do_reset();
    snap();
    cyc(1, 1, 32'h0040_0040, 32'h0040_0400, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 1, 1, 0, 0, 1);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    idle(3);
    check("t3_pw_count", pw_total - pw_base, 0);
    check("t3_bm_count", bm_total - bm_base, 1);
    check("t3_branch_cnt",  branch_cnt, 1);
    check("t3_mispred_cnt", mispred_cnt, 0);

    // Mispredict, E stalled 4 cycles, then M stalled 2 cycles
    do_reset();
    snap();
    cyc(1, 0, 32'h0040_0060, 32'h0040_0600, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, '0, 1, 1, 0, 0, 1);
    check("t4_pulse_first", pred_wrongE, 1);
    check("t4_redirect",    redirect_pcE, 32'h0040_0600);
    cyc(0, 0, '0, '0, 1, 1, 0, 0, 1);
    check("t4_pulse_held", pred_wrongE, 0);
    cyc(0, 0, '0, '0, 1, 1, 0, 0, 1);
    cyc(0, 0, '0, '0, 1, 1, 0, 0, 1);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    check("t4_pulse_release", pred_wrongE, 0);
    cyc(0, 0, '0, '0, 0, 1, 0, 1, 0);
    check("t4_branchM_first", branchM, 1);
    check("t4_pcM", pcM, 32'h0040_0060);
    cyc(0, 0, '0, '0, 0, 1, 0, 1, 0);
    check("t4_branchM_held", branchM, 0);
    idle(3);
    check("t4_pw_count", pw_total - pw_base, 1);
    check("t4_bm_count", bm_total - bm_base, 1);
    check("t4_branch_cnt",  branch_cnt, 1);
    check("t4_mispred_cnt", mispred_cnt, 1);

    // flushE as the branch would enter E: nothing retires
    snap();
    cyc(1, 0, 32'h0040_0080, 32'h0040_0800, 0, 0, 1, 0, 0);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    check("t5_no_pulse", pred_wrongE, 0);
    idle(3);
    check("t5_pw_count", pw_total - pw_base, 0);
    check("t5_bm_count", bm_total - bm_base, 0);
    check("t5_branch_cnt",  branch_cnt, 1);
    check("t5_mispred_cnt", mispred_cnt, 1);

    // flushE in the same cycle as a mispredict: pulse still fires
    cyc(1, 0, 32'h0040_00a0, 32'h0040_0a00, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'h0040_00b0, 32'h0040_0b00, 1, 0, 1, 0, 0);
    check("t6_pulse", pred_wrongE, 1);
    check("t6_redirect", redirect_pcE, 32'h0040_0a00);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    check("t6_bubble", pred_wrongE, 0);
    idle(2);

    // Saturation: 15 back-to-back mispredicts, then one more
    do_reset();
    snap();
    for (int i = 0; i < 15; i++)
      cyc(1, 0, 32'h0040_1000 + 32'(i * 8), 32'h0040_2000, 1, 0, 0, 0, 0);
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    idle(3);
    check("t7_branch_cnt_15",  branch_cnt, 4'hf);
    check("t7_mispred_cnt_15", mispred_cnt, 4'hf);
    cyc(1, 1, 32'h0040_3000, 32'h0040_4000, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, '0, 0, 0, 0, 0, 0);
    check("t7_pulse_16", pred_wrongE, 1);
    idle(3);
    check("t7_branch_cnt_sat",  branch_cnt, 4'hf);
    check("t7_mispred_cnt_sat", mispred_cnt, 4'hf);
    check("t7_pw_count", pw_total - pw_base, 16);
    check("t7_bm_count", bm_total - bm_base, 16);

    // Reset while a mispredicting branch is stalled in E
    cyc(1, 0, 32'h0040_5000, 32'h0040_6000, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, '0, '0, 1, 1, 0, 1, 0);
    check("t8_no_pulse_in_rst", pred_wrongE, 0);
    check("t8_no_branchM_in_rst", branchM, 0);
    rst = 1'b0;
    cyc(0, 0, '0, '0, 1, 0, 0, 0, 0);
    check("t8_pred_wrong", pred_wrongE, 0);
    check("t8_redirect",   redirect_pcE, 0);
    check("t8_branchM",    branchM, 0);
    check("t8_pcM",        pcM, 0);
    check("t8_actualM",    actual_takeM, 0);
    check("t8_branch_cnt", branch_cnt, 0);
    check("t8_mispred_cnt", mispred_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
